// File: rtl/sp_feature_collector.sv
// sp_feature_collector: walks every (channel, SP index) pair, pulses the SP
// extractor once per element, collects each returned value into a packed
// feature array and presents the full array with a one-cycle feat_valid.
// A per-element timeout stores 0 and flags err if the extractor never answers.
//
// Ports:
//   clk, rst     sole clock (rising edge), asynchronous active-high reset
//   start        run request, sampled only while idle
//   busy         high whenever a run is in progress
//   sp_en        one-cycle extractor enable per element
//   sp_c, sp_spi current channel / SP index presented to the extractor
//   sp_done      extractor result strobe; sp_spv is its value
//   feat         collected features, feat[c][spi]
//   feat_valid   one-cycle pulse, feat is complete
//   err          sticky, an element timed out during this run
module sp_feature_collector #(
  parameter int unsigned NUM_CHS = 17,
  parameter int unsigned NUM_SPI = 6,
  parameter int unsigned NUM_SPV = 64,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned SPV_W = $clog2(NUM_SPV),
  localparam int unsigned C_W   = $clog2(NUM_CHS),
  localparam int unsigned SPI_W = $clog2(NUM_SPI)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         sp_en,
  output logic [C_W-1:0]                               sp_c,
  output logic [SPI_W-1:0]                             sp_spi,
  input  logic                                         sp_done,
  input  logic [SPV_W-1:0]                             sp_spv,
  output logic [NUM_CHS-1:0][NUM_SPI-1:0][SPV_W-1:0]   feat,
  output logic                                         feat_valid,
  output logic                                         err
);

  localparam int unsigned TM_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [TM_W-1:0]   timer;
  logic [TM_W-1:0]   timer_next;
  logic [C_W-1:0]    c_next;
  logic [SPI_W-1:0]  spi_next;
  logic              err_next;
  logic              wr_en;
  logic [SPV_W-1:0]  wr_val;
  logic              advance;
  logic              last_elem;

  assign last_elem = (sp_c == C_W'(NUM_CHS - 1)) && (sp_spi == SPI_W'(NUM_SPI - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, index walk, timeout and capture decode
  always_comb begin
    state_next = state;
    timer_next = timer;
    c_next     = sp_c;
    spi_next   = sp_spi;
    err_next   = err;
    wr_en      = 1'b0;
    wr_val     = '0;
    advance    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          err_next   = 1'b0;
          c_next     = '0;
          spi_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A result arriving on the final timeout cycle still wins.
        if (sp_done) begin
          wr_en   = 1'b1;
          wr_val  = sp_spv;
          advance = 1'b1;
        end else if (timer == TM_W'(TIMEOUT - 1)) begin
          wr_en    = 1'b1;
          err_next = 1'b1;
          advance  = 1'b1;
        end else begin
          timer_next = timer + TM_W'(1);
        end
        if (advance) begin
          if (last_elem) begin
            state_next = DONE;
          end else begin
            state_next = ISSUE;
            if (sp_spi == SPI_W'(NUM_SPI - 1)) begin
              spi_next = '0;
              c_next   = sp_c + C_W'(1);
            end else begin
              spi_next = sp_spi + SPI_W'(1);
            end
          end
        end
      end
      DONE: begin
        c_next     = '0;
        spi_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and status registers; strobes decode from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      sp_en      <= 1'b0;
      feat_valid <= 1'b0;
      err        <= 1'b0;
      sp_c       <= '0;
      sp_spi     <= '0;
      timer      <= '0;
    end else begin
      busy       <= (state_next != IDLE);
      sp_en      <= (state_next == ISSUE);
      feat_valid <= (state_next == DONE);
      err        <= err_next;
      sp_c       <= c_next;
      sp_spi     <= spi_next;
      timer      <= timer_next;
    end
  end

  // Feature array; only WAIT captures write it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        feat               <= '0;
    else if (wr_en) feat[sp_c][sp_spi] <= wr_val;
  end

endmodule

// File: tb/tb_sp_feature_collector.sv
// Scoreboard bench for sp_feature_collector: an extractor model answers
// sp_en requests, each run's expected features/err/feat_valid cycle are
// queued at start, and a monitor compares whenever the DUT presents results.
module tb_sp_feature_collector;

  localparam int NCH  = 17;
  localparam int NSP  = 6;
  localparam int SPVW = 6;
  localparam int TMO  = 16;
  localparam int NEL  = NCH * NSP;

  typedef logic [NCH-1:0][NSP-1:0][SPVW-1:0] feat_t;
  typedef struct packed {
    feat_t f;
    logic  err;
    int    scyc;
    int    fv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        sp_en;
  logic [4:0]  sp_c;
  logic [2:0]  sp_spi;
  logic        sp_done;
  logic [SPVW-1:0] sp_spv;
  feat_t       feat;
  logic        feat_valid;
  logic        err;

  sp_feature_collector #(
    .NUM_CHS(NCH), .NUM_SPI(NSP), .NUM_SPV(64), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .sp_en(sp_en),
    .sp_c(sp_c), .sp_spi(sp_spi), .sp_done(sp_done), .sp_spv(sp_spv),
    .feat(feat), .feat_valid(feat_valid), .err(err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Extractor model configuration (changed only while idle)
  feat_t vals;
  int    lat;
  int    miss_k;
  int    coll_k;
  bit    stray;

  exp_t exp_q[$];
  int   nvec  = 0;
  int   nfail = 0;

  function automatic feat_t nominal_vals();
    feat_t r;
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < NSP; p++)
        r[c][p] = SPVW'((c * NSP + p) % 64);
    return r;
  endfunction

  function automatic feat_t rand_vals();
    feat_t r;
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < NSP; p++)
        r[c][p] = SPVW'($urandom);
    return r;
  endfunction

  // Expected outcome of a run started in cycle s, from the element rules.
  function automatic exp_t build(feat_t v, int s);
    exp_t e;
    int total;
    int c;
    int p;
    e.f   = '0;
    e.err = 1'b0;
    total = 0;
    for (int k = 0; k < NEL; k++) begin
      c = k / NSP;
      p = k % NSP;
      if (k == miss_k) begin
        e.f[c][p] = '0;
        e.err     = 1'b1;
        total     = total + 1 + TMO;
      end else begin
        e.f[c][p] = v[c][p];
        total     = total + 1 + ((k == coll_k) ? TMO : lat);
      end
    end
    e.scyc = s;
    e.fv   = s + 1 + total;
    return e;
  endfunction

  // Extractor model: answers lat cycles after sp_en, withholds miss_k,
  // optionally injects stray strobes outside WAIT.
  initial begin
    int pend;
    int k;
    logic [SPVW-1:0] pv;
    pend    = 0;
    pv      = '0;
    sp_done = 1'b0;
    sp_spv  = '0;
    forever begin
      @(posedge clk);
      #1;
      sp_done = 1'b0;
      sp_spv  = '0;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend = pend - 1;
          if (pend == 0) begin
            sp_done = 1'b1;
            sp_spv  = pv;
          end
        end
        if (sp_en) begin
          k = int'(sp_c) * NSP + int'(sp_spi);
          if (k != miss_k) begin
            pend = (k == coll_k) ? TMO : lat;
            pv   = vals[sp_c][sp_spi];
          end
          if (stray) begin
            sp_done = 1'b1;
            sp_spv  = SPVW'($urandom);
          end
        end else if (stray && (!busy || feat_valid) && !sp_done &&
                     $urandom_range(0, 1) == 1) begin
          sp_done = 1'b1;
          sp_spv  = SPVW'($urandom);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    nvec = nvec + 1;
    if (got != want) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic chk_feat(input string nm, input feat_t got, input feat_t want);
    nvec = nvec + 1;
    if (got != want) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: sole consumer of the scoreboard and sole owner of the counters.
  initial begin
    int    en_idx;
    feat_t last_feat;
    logic  last_err;
    exp_t  e;
    en_idx    = 0;
    last_feat = '0;
    last_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_ctl", int'({busy, sp_en, feat_valid, err}), 0);
        chk("reset_idx", int'({sp_c, sp_spi}), 0);
        chk_feat("reset_feat", feat, '0);
        exp_q.delete();
        en_idx    = 0;
        last_feat = '0;
        last_err  = 1'b0;
      end else begin
        if (sp_en) begin
          chk("en_c", int'(sp_c), en_idx / NSP);
          chk("en_spi", int'(sp_spi), en_idx % NSP);
          chk("en_busy", int'(busy), 1);
          if (en_idx == 0) begin
            chk("err_cleared", int'(err), 0);
            if (exp_q.size() > 0) chk("first_issue_cycle", cyc, exp_q[0].scyc + 1);
          end
          en_idx = en_idx + 1;
        end
        if (feat_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_feat_valid", int'(feat_valid), 0);
          end else begin
            e = exp_q.pop_front();
            chk("feat_valid_cycle", cyc, e.fv);
            chk("err", int'(err), int'(e.err));
            chk("en_count", en_idx, NEL);
            for (int c = 0; c < NCH; c++)
              for (int p = 0; p < NSP; p++)
                chk($sformatf("feat[%0d][%0d]", c, p), int'(feat[c][p]), int'(e.f[c][p]));
            last_feat = e.f;
            last_err  = e.err;
          end
          en_idx = 0;
        end else if (!busy) begin
          chk_feat("idle_feat_hold", feat, last_feat);
          chk("idle_err_hold", int'(err), int'(last_err));
          chk("idle_no_en", int'(sp_en), 0);
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].fv + 4) begin
          chk("feat_valid_by_deadline", int'(feat_valid), 1);
          void'(exp_q.pop_front());
          en_idx = 0;
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_run();
    @(posedge clk);
    #1;
    start = 1'b1;
    exp_q.push_back(build(vals, cyc));
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
  endtask

  task automatic back_to_back();
    exp_t  e1;
    exp_t  e2;
    feat_t v1;
    feat_t v2;
    v1 = rand_vals();
    v2 = rand_vals();
    vals = v1;
    @(posedge clk);
    #1;
    start = 1'b1;
    e1 = build(v1, cyc);
    e2 = build(v2, e1.fv + 1);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    for (int i = 0; i < 1000 && cyc < e1.fv; i++) begin
      @(posedge clk);
      #1;
    end
    vals = v2;
    for (int i = 0; i < 10 && cyc < e1.fv + 3; i++) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    drain();
  endtask

  task automatic reset_mid_run();
    int s;
    vals = rand_vals();
    @(posedge clk);
    #1;
    start = 1'b1;
    s = cyc;
    exp_q.push_back(build(vals, s));
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && cyc < s + 50; i++) begin
      @(posedge clk);
      #1;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    lat    = 1;
    miss_k = -1;
    coll_k = -1;
    stray  = 1'b0;
    vals   = nominal_vals();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    // nominal
    do_run();
    // missing response at (3,2), then err clears on the following run
    miss_k = 3 * NSP + 2;
    vals   = rand_vals();
    do_run();
    miss_k = -1;
    vals   = rand_vals();
    do_run();
    // late response with stray strobes outside WAIT
    lat   = 3;
    stray = 1'b1;
    vals  = rand_vals();
    do_run();
    repeat (6) @(posedge clk);
    #1 stray = 1'b0;
    // back-to-back with start held high
    lat = 1;
    back_to_back();
    // reset mid-run, then a nominal run
    reset_mid_run();
    vals = nominal_vals();
    do_run();
    // done coinciding with the last timeout cycle
    coll_k = $urandom_range(0, NEL - 1);
    vals   = rand_vals();
    do_run();
    coll_k = -1;
    // randomized runs
    for (int r = 0; r < 3; r++) begin
      lat    = $urandom_range(1, 5);
      miss_k = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NEL - 1) : -1;
      coll_k = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NEL - 1) : -1;
      stray  = ($urandom_range(0, 1) == 1);
      vals   = rand_vals();
      do_run();
    end
    stray = 1'b0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sp_feature_collector.md
# sp_feature_collector

Sequencer and collector directly downstream of the spatial-pattern (SP) extractor. On `start` it walks every channel `c` and SP index `spi`, pulses the extractor's `en` once per element and waits for `done`. It stores each returned `spv` into a packed feature array, then presents the full array to the HDC encoder with a one-cycle `feat_valid`. A per-element timeout keeps the run going if the extractor never answers.

## Interface
- `NUM_CHS`, 17: EEG channels walked, outer loop.
- `NUM_SPI`, 6: SP indices per channel, inner loop.
- `NUM_SPV`, 64: SP value range; `SPV_W = $clog2(NUM_SPV)`.
- `TIMEOUT`, 16: maximum WAIT cycles per element; must be ≥ 2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high whenever state ≠ IDLE.
- `sp_en`  out  1  extractor enable; high only in ISSUE.
- `sp_c`  out  $clog2(NUM_CHS)  current channel index.
- `sp_spi`  out  $clog2(NUM_SPI)  current SP index.
- `sp_done`  in  1  extractor result strobe.
- `sp_spv`  in  SPV_W  extractor result; valid when `sp_done` = 1.
- `feat`  out  [NUM_CHS-1:0][NUM_SPI-1:0][SPV_W-1:0]  collected features.
- `feat_valid`  out  1  one-cycle pulse; `feat` is complete.
- `err`  out  1  sticky; at least one element timed out this run.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs decode from registers; there is no combinational input-to-output path.
- IDLE, `start` = 1: clear `err`, set `sp_c` = 0 and `sp_spi` = 0, go to ISSUE. `start` in any other state is ignored.
- ISSUE: `sp_en` = 1 for exactly one cycle, clear the timer, go to WAIT.
- WAIT, `sp_done` = 1:
  - write `feat[sp_c][sp_spi] <= sp_spv`;
  - if this is the last element (`sp_c` = NUM_CHS-1 and `sp_spi` = NUM_SPI-1), go to DONE;
  - otherwise advance the indices and go to ISSUE.
- WAIT, `sp_done` = 0: increment the timer. When the timer reaches TIMEOUT-1:
  - write `feat[sp_c][sp_spi] <= 0` and set `err` = 1;
  - advance exactly as on `sp_done`.
- If `sp_done` and the timeout coincide, `sp_done` wins: the value is stored and `err` is not set.
- Index advance: `sp_spi` increments. When `sp_spi` = NUM_SPI-1 it wraps to 0 and `sp_c` increments. There is no wrap past the last element.
- DONE: `feat_valid` = 1 for one cycle, `sp_c` and `sp_spi` return to 0, go to IDLE.
- `sp_done` seen in IDLE, ISSUE or DONE is ignored; `feat` is unchanged.
- `feat` elements change only on WAIT captures. Outside a run they hold their last values, including the previous run's results.
- `err` holds until the next accepted `start` or `rst`.
- Reset values: state IDLE; `busy`, `sp_en`, `feat_valid`, `err` = 0; `sp_c`, `sp_spi` = 0; all `feat` = 0.
- `rst` asserted mid-run aborts immediately with no `feat_valid`. After deassertion the block waits in IDLE for a new `start`.

## Timing
- `start` high in cycle 0: ISSUE in cycle 1, `busy` rises in cycle 1.
- Extractor answering one cycle after `en`: each element costs 2 cycles (ISSUE, WAIT).
- With that extractor, the last capture is at the end of cycle 204, `feat_valid` and DONE are in cycle 205, and IDLE returns in cycle 206.
- General latency: start-to-`feat_valid` = 1 + Σ(1 + WAIT cycles per element).
- A timed-out element occupies TIMEOUT WAIT cycles.
- `start` held high continuously: the next run begins with ISSUE in cycle 207, leaving one IDLE cycle between runs.

## Test plan
- Nominal run: model `done` one cycle after `en`, `spv` = (c·6+spi) mod 64, `start` pulse in cycle 0.
  - `feat_valid` pulses only in cycle 205.
  - Every `feat[c][spi]` matches the model, `err` = 0.
  - Exactly 102 `sp_en` pulses, indices in order (0,0)…(16,5).
- Missing response: model withholds `done` for (c=3, spi=2).
  - `feat[3][2]` = 0, `err` = 1, all other elements correct.
  - `feat_valid` in cycle 220.
  - `err` clears on the next `start`.
- Late response and stray strobes: model answers 3 cycles after `en`.
  - All values are captured correctly and `feat_valid` arrives in cycle 409.
  - Extra `sp_done` pulses injected in IDLE and ISSUE leave `feat` unchanged.
- Back-to-back runs: `start` held high with model values changing between runs.
  - Second run's ISSUE in cycle 207.
  - `start` during `busy` has no effect.
  - Second `feat` reflects the new values.
- Reset mid-run: `rst` asserted in cycle 50.
  - All outputs return to their reset values asynchronously, with no `feat_valid`.
  - A subsequent `start` completes normally with the nominal 205-cycle latency.
- Timeout versus `done` collision: `done` arrives exactly on WAIT cycle TIMEOUT.
  - The value is stored and `err` stays 0.
